// File: rtl/multibit_fifo_arb.sv
// Round-robin arbiter feeding one registered FIFO write port.
// Burst locking is enabled by defining MULTIBIT_FIFO_ARB_LOCK_EN.
module multibit_fifo_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
`ifdef MULTIBIT_FIFO_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_last,
`endif
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0]    out_id,
  input  logic                          out_ready
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [ID_WIDTH-1:0]   last_grant;
  logic [ID_WIDTH-1:0]   rr_id;
  logic                  rr_hit;
  logic [ID_WIDTH-1:0]   cand;
  logic [ID_WIDTH-1:0]   grant;
  logic                  hit;
  logic                  load_en;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;

  // First valid requester after last_grant, wrapping around.
  always_comb begin
    rr_hit = 1'b0;
    rr_id  = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      if (!rr_hit && req_valid[cand]) begin
        rr_hit = 1'b1;
        rr_id  = cand;
      end
    end
  end

`ifdef MULTIBIT_FIFO_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;

  state_t              state, state_n;
  logic [ID_WIDTH-1:0] lock_id, lock_id_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB;
      lock_id <= '0;
    end else begin
      state   <= state_n;
      lock_id <= lock_id_n;
    end
  end

  always_comb begin
    state_n   = state;
    lock_id_n = lock_id;
    grant     = rr_id;
    hit       = rr_hit;
    unique case (state)
      ARB: begin
        if (accept && !req_last[grant]) begin
          state_n   = LOCKED;
          lock_id_n = grant;
        end
      end
      LOCKED: begin
        grant = lock_id;
        hit   = req_valid[lock_id];
        if (accept && req_last[lock_id])
          state_n = ARB;
      end
    endcase
  end
`else
  always_comb begin
    grant = rr_id;
    hit   = rr_hit;
  end
`endif

  assign load_en  = ~out_valid | out_ready;
  assign accept   = hit & load_en & ~reset;
  assign sel_data = req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready = NUM_REQ'(1) << grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= sel_data;
      out_id     <= grant;
      last_grant <= grant;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multibit_fifo_arb.sv
// Directed bench for multibit_fifo_arb (4 requesters, 32-bit data).
// Lock steps run only when MULTIBIT_FIFO_ARB_LOCK_EN is defined.
module tb_multibit_fifo_arb;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
`ifdef MULTIBIT_FIFO_ARB_LOCK_EN
  logic [N-1:0]    req_last;
`endif
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            out_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multibit_fifo_arb #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
`ifdef MULTIBIT_FIFO_ARB_LOCK_EN
    .req_last  (req_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  function automatic logic [31:0] pay(input int i);
    return 32'hD000_0000 | 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [1:0] id, input logic [31:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".id"}, 32'(out_id), 32'(id));
    chk({tag, ".data"}, out_data, d);
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      req_data[i*DW +: DW] = pay(i);
    reset     = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
`ifdef MULTIBIT_FIFO_ARB_LOCK_EN
    req_last  = '0;
`endif
    tick();
    tick();
    chk_out("reset", 1'b0, 2'd0, 32'h0);
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    tick();
    chk("rst_hold_valid", 32'(out_valid), 32'h0);

    // All requesters busy, sink always ready: 0,1,2,3,0
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rr_ready0", 32'(req_ready), 32'b0001);
    tick();
    chk_out("rr0", 1'b1, 2'd0, pay(0));
    chk("rr_ready1", 32'(req_ready), 32'b0010);
    tick();
    chk_out("rr1", 1'b1, 2'd1, pay(1));
    tick();
    chk_out("rr2", 1'b1, 2'd2, pay(2));
    tick();
    chk_out("rr3", 1'b1, 2'd3, pay(3));
    tick();
    chk_out("rr4", 1'b1, 2'd0, pay(0));

    // Backpressure freezes the register
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 4'b0101;
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'b0001);
    tick();
    chk_out("bp_load", 1'b1, 2'd0, pay(0));
    for (int c = 0; c < 5; c++) begin
      chk("bp_noready", 32'(req_ready), 32'h0);
      tick();
      chk_out("bp_hold", 1'b1, 2'd0, pay(0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0100);
    tick();
    chk_out("bp_next", 1'b1, 2'd2, pay(2));

    // Wrap-around search from last_grant=3
    req_valid = 4'b1000;
    #1;
    chk("wrap_pre_ready", 32'(req_ready), 32'b1000);
    tick();
    chk_out("wrap_pre", 1'b1, 2'd3, pay(3));
    req_valid = 4'b0010;
    #1;
    chk("wrap_ready", 32'(req_ready), 32'b0010);
    tick();
    chk_out("wrap", 1'b1, 2'd1, pay(1));

    // Drain, then idle; last_grant must stay at 1
    req_valid = '0;
    tick();
    chk_out("drain", 1'b0, 2'd1, pay(1));
    out_ready = 1'b0;
    tick();
    chk("idle_valid", 32'(out_valid), 32'h0);
    req_valid = 4'b1111;
    #1;
    chk("idle_keep_grant", 32'(req_ready), 32'b0100);
    tick();
    chk_out("load_from_idle", 1'b1, 2'd2, pay(2));

    // Reset mid-operation discards the held beat
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    chk_out("mid_rst", 1'b0, 2'd0, 32'h0);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    tick();
    chk_out("post_rst", 1'b1, 2'd0, pay(0));

`ifdef MULTIBIT_FIFO_ARB_LOCK_EN
    // Requester 2 holds a three-beat burst
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    out_ready = 1'b1;
    tick();
    chk_out("lock_b0", 1'b1, 2'd2, pay(2));
    req_valid = 4'b1111;
    #1;
    chk("lock_ready", 32'(req_ready), 32'b0100);
    tick();
    chk_out("lock_b1", 1'b1, 2'd2, pay(2));
    req_valid = 4'b1011;
    #1;
    chk("lock_stall_ready", 32'(req_ready), 32'h0);
    tick();
    chk("lock_stall_valid", 32'(out_valid), 32'h0);
    req_valid = 4'b1111;
    req_last  = 4'b0100;
    tick();
    chk_out("lock_b2", 1'b1, 2'd2, pay(2));
    tick();
    chk_out("lock_release", 1'b1, 2'd3, pay(3));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
